// File: rtl/ap_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ap_seq_pkg
// Purpose  : Shared state encoding and sizing helpers for ap_ctrl_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package ap_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } seq_state_t;

    // Width needed to hold 0..max_outstanding inclusive
    function automatic int outst_width(input int max_outstanding);
        return $clog2(max_outstanding + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ap_seq_ts_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ap_seq_ts_fifo
// Purpose  : Small synchronous FIFO holding start timestamps; push and pop in
//            the same cycle are both honoured, pop on empty is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module ap_seq_ts_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full
);

    localparam int                 c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                 c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == c_FULL);
    assign w_do_pop  = i_pop && !o_empty;
    // A full FIFO can still accept when a slot frees up in the same cycle
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + c_PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ap_ctrl_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ap_ctrl_sequencer
// Purpose  : Drives the ap_ctrl_chain handshake of one HLS kernel for a
//            commanded number of invocations with bounded overlap.
//            Optional latency statistics: define AP_SEQ_LAT_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ap_ctrl_sequencer
    import ap_seq_pkg::*;
#(
    parameter int CNT_W           = 16,
    parameter int MAX_OUTSTANDING = 2,
    parameter int TS_W            = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    input  logic [CNT_W-1:0] cmd_count,
    output logic             cmd_ready,
    output logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    output logic             ap_continue,
    input  logic             sink_ready,
    output logic             busy,
    output logic             finish,
    output logic [CNT_W-1:0] starts_issued,
    output logic [CNT_W-1:0] dones_seen,
    output logic             err_spurious,
    output logic [TS_W-1:0]  lat_min,
    output logic [TS_W-1:0]  lat_max,
    output logic             lat_valid
);

    localparam int                 c_OUT_W   = outst_width(MAX_OUTSTANDING);
    localparam logic [c_OUT_W-1:0] c_MAX_OUT = c_OUT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0]   c_CNT_MAX = {CNT_W{1'b1}};

    seq_state_t         r_state;
    seq_state_t         w_state_nxt;
    logic [CNT_W-1:0]   r_remaining;
    logic [CNT_W-1:0]   w_rem_nxt;
    logic [c_OUT_W-1:0] r_outstanding;
    logic [c_OUT_W-1:0] w_outst_nxt;
    logic               r_ap_start;
    logic               w_start_nxt;
    logic               w_clear;
    logic               w_start_hs;
    logic               w_done_hs;
    logic               w_spurious;
    logic [CNT_W-1:0]   r_starts;
    logic [CNT_W-1:0]   r_dones;
    logic               r_err;

    assign ap_start      = r_ap_start;
    assign ap_continue   = sink_ready && ((r_state == RUN) || (r_state == DRAIN));
    assign cmd_ready     = (r_state == IDLE);
    assign busy          = (r_state != IDLE);
    assign finish        = (r_state == FINISH);
    assign starts_issued = r_starts;
    assign dones_seen    = r_dones;
    assign err_spurious  = r_err;

    assign w_start_hs = r_ap_start && ap_ready;
    assign w_done_hs  = ap_done && ap_continue;
    assign w_spurious = w_done_hs && (r_outstanding == '0);

    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_remaining;
        w_outst_nxt = r_outstanding;
        w_start_nxt = 1'b0;
        w_clear     = 1'b0;

        if (w_start_hs) begin
            w_rem_nxt = r_remaining - CNT_W'(1);
        end

        // A simultaneous start and done cancel; a spurious done never underflows
        case ({w_start_hs, w_done_hs})
            2'b10:   w_outst_nxt = r_outstanding + c_OUT_W'(1);
            2'b01:   w_outst_nxt = w_spurious ? r_outstanding : r_outstanding - c_OUT_W'(1);
            default: w_outst_nxt = r_outstanding;
        endcase

        case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_count != '0) begin
                        w_rem_nxt   = cmd_count;
                        w_clear     = 1'b1;
                        w_state_nxt = RUN;
                    end else begin
                        w_state_nxt = FINISH;
                    end
                end
            end
            RUN: begin
                if (w_start_hs && (r_remaining == CNT_W'(1))) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (w_outst_nxt == '0) begin
                    w_state_nxt = FINISH;
                end
            end
            FINISH: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // ap_start must persist until ap_ready, then re-arms only if allowed
        if (w_state_nxt == RUN) begin
            w_start_nxt = (r_ap_start && !ap_ready) ||
                          ((w_rem_nxt != '0) && (w_outst_nxt < c_MAX_OUT));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= IDLE;
            r_remaining   <= '0;
            r_outstanding <= '0;
            r_ap_start    <= 1'b0;
            r_starts      <= '0;
            r_dones       <= '0;
            r_err         <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_remaining   <= w_rem_nxt;
            r_outstanding <= w_outst_nxt;
            r_ap_start    <= w_start_nxt;
            if (w_clear) begin
                r_starts <= '0;
                r_dones  <= '0;
                r_err    <= 1'b0;
            end else begin
                if (w_start_hs && (r_starts != c_CNT_MAX)) begin
                    r_starts <= r_starts + CNT_W'(1);
                end
                if (w_done_hs && (r_dones != c_CNT_MAX)) begin
                    r_dones <= r_dones + CNT_W'(1);
                end
                if (w_spurious) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

`ifdef AP_SEQ_LAT_STATS_EN
    logic [TS_W-1:0] r_ts;
    logic [TS_W-1:0] w_ts_head;
    logic [TS_W-1:0] w_lat;
    logic [TS_W-1:0] r_lat_min;
    logic [TS_W-1:0] r_lat_max;
    logic            r_lat_valid;
    logic            w_ts_empty;
    logic            w_ts_full;
    logic            w_ts_push;
    logic            w_ts_pop;
    logic            w_cmd_accept;

    assign w_ts_pop     = w_done_hs && !w_ts_empty;
    assign w_ts_push    = w_start_hs && (!w_ts_full || w_ts_pop);
    assign w_lat        = r_ts - w_ts_head;
    assign w_cmd_accept = (r_state == IDLE) && cmd_valid;

    ap_seq_ts_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (TS_W)
    ) u_ts_fifo (
        .clk     (clock),
        .rst     (reset),
        .i_push  (w_ts_push),
        .i_data  (r_ts),
        .i_pop   (w_ts_pop),
        .o_data  (w_ts_head),
        .o_empty (w_ts_empty),
        .o_full  (w_ts_full)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ts        <= '0;
            r_lat_min   <= '0;
            r_lat_max   <= '0;
            r_lat_valid <= 1'b0;
        end else begin
            r_ts <= r_ts + TS_W'(1);
            if (w_cmd_accept) begin
                r_lat_min   <= '0;
                r_lat_max   <= '0;
                r_lat_valid <= 1'b0;
            end else if (w_ts_pop) begin
                if (!r_lat_valid) begin
                    r_lat_min   <= w_lat;
                    r_lat_max   <= w_lat;
                    r_lat_valid <= 1'b1;
                end else begin
                    if (w_lat < r_lat_min) r_lat_min <= w_lat;
                    if (w_lat > r_lat_max) r_lat_max <= w_lat;
                end
            end
        end
    end

    assign lat_min   = r_lat_min;
    assign lat_max   = r_lat_max;
    assign lat_valid = r_lat_valid;
`else
    assign lat_min   = '0;
    assign lat_max   = '0;
    assign lat_valid = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ap_ctrl_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ap_ctrl_sequencer
// Purpose  : Self-checking bench with a behavioural kernel and a run scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ap_ctrl_sequencer;

    localparam int CNT_W   = 16;
    localparam int MAX_OUT = 2;
    localparam int TS_W    = 32;

    logic             clock = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic [CNT_W-1:0] cmd_count;
    logic             cmd_ready;
    logic             ap_start;
    logic             ap_ready;
    logic             ap_done;
    logic             ap_continue;
    logic             sink_ready;
    logic             busy;
    logic             finish;
    logic [CNT_W-1:0] starts_issued;
    logic [CNT_W-1:0] dones_seen;
    logic             err_spurious;
    logic [TS_W-1:0]  lat_min;
    logic [TS_W-1:0]  lat_max;
    logic             lat_valid;

    always #5 clock = ~clock;

    ap_ctrl_sequencer #(
        .CNT_W           (CNT_W),
        .MAX_OUTSTANDING (MAX_OUT),
        .TS_W            (TS_W)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_count     (cmd_count),
        .cmd_ready     (cmd_ready),
        .ap_start      (ap_start),
        .ap_ready      (ap_ready),
        .ap_done       (ap_done),
        .ap_continue   (ap_continue),
        .sink_ready    (sink_ready),
        .busy          (busy),
        .finish        (finish),
        .starts_issued (starts_issued),
        .dones_seen    (dones_seen),
        .err_spurious  (err_spurious),
        .lat_min       (lat_min),
        .lat_max       (lat_max),
        .lat_valid     (lat_valid)
    );

    typedef struct {
        int starts;
        int dones;
    } run_t;

    run_t sb_q[$];
    int   due_q[$];
    int   dly_q[$];
    int   n_vec     = 0;
    int   n_miss    = 0;
    int   cyc       = 0;
    int   out_m     = 0;
    int   n_finish  = 0;
    int   n_rise    = 0;
    int   n_both    = 0;
    int   f_base    = 0;
    bit   k_done_en = 1'b1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: observe handshakes before the edge, then update outputs-side checks and kernel
    task automatic tick();
        bit   hs_s;
        bit   hs_d;
        bit   pstart;
        bit   preset;
        int   s_before;
        int   d_before;
        run_t r;
        @(negedge clock);
        hs_s     = ap_start && ap_ready;
        hs_d     = ap_done && ap_continue;
        pstart   = ap_start;
        preset   = reset;
        s_before = int'(starts_issued);
        d_before = int'(dones_seen);
        if (!preset) begin
            if (hs_s) begin
                due_q.push_back(cyc + ((dly_q.size() > 0) ? dly_q.pop_front() : 5));
            end
            if (hs_d && due_q.size() > 0) void'(due_q.pop_front());
            if (hs_s && !hs_d) out_m++;
            else if (!hs_s && hs_d && out_m > 0) out_m--;
        end
        @(posedge clock);
        #1;
        cyc++;
        if (!preset) begin
            if (pstart && !hs_s) chk("ap_start_hold", ap_start, 1);
            if (ap_start && (!pstart || hs_s)) chk("start_under_max", out_m < MAX_OUT, 1);
            if (hs_s && hs_d) begin
                n_both++;
                chk("both_hs_starts", starts_issued, s_before + 1);
                chk("both_hs_dones", dones_seen, d_before + 1);
            end
        end
        if (!pstart && ap_start) n_rise++;
        if (finish) begin
            n_finish++;
            chk("sb_pending", sb_q.size() > 0, 1);
            if (sb_q.size() > 0) begin
                r = sb_q.pop_front();
                chk("run_starts", starts_issued, r.starts);
                chk("run_dones", dones_seen, r.dones);
            end
        end
        ap_ready = ap_start && pstart && !hs_s;
        if (k_done_en && due_q.size() > 0) ap_done = (due_q[0] <= cyc);
        else ap_done = 1'b0;
    endtask

    task automatic issue_cmd(input int count, input int exp_s, input int exp_d, input bit push);
        run_t r;
        r.starts  = exp_s;
        r.dones   = exp_d;
        f_base    = n_finish;
        cmd_valid = 1'b1;
        cmd_count = CNT_W'(count);
        if (push) sb_q.push_back(r);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_finish(input int bound);
        int k;
        k = 0;
        while (n_finish == f_base && k < bound) begin
            tick();
            k++;
        end
        chk("finish_count", n_finish - f_base, 1);
        tick();
        chk("finish_one_cycle", finish, 0);
        chk("busy_idle", busy, 0);
        chk("cmd_ready_idle", cmd_ready, 1);
    endtask

    task automatic chk_lat(input int mn, input int mx, input bit vld);
`ifdef AP_SEQ_LAT_STATS_EN
        chk("lat_min", lat_min, mn);
        chk("lat_max", lat_max, mx);
        chk("lat_valid", lat_valid, vld);
`else
        chk("lat_min_tied", lat_min, (mn & 0));
        chk("lat_max_tied", lat_max, (mx & 0));
        chk("lat_valid_tied", lat_valid, (vld & 1'b0));
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int d0;
        int f0;
        int r0;
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_count  = '0;
        ap_ready   = 1'b0;
        ap_done    = 1'b0;
        sink_ready = 1'b1;
        repeat (3) tick();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ap_start", ap_start, 0);
        chk("rst_ap_continue", ap_continue, 0);
        chk("rst_finish", finish, 0);
        chk("rst_starts", starts_issued, 0);
        chk("rst_dones", dones_seen, 0);
        chk("rst_err", err_spurious, 0);
        chk_lat(0, 0, 0);
        reset = 1'b0;
        tick();

        // Basic run of three invocations, latency 5 each
        issue_cmd(3, 3, 3, 1);
        chk("run_busy", busy, 1);
        chk("run_cmd_ready", cmd_ready, 0);
        wait_finish(200);
        chk_lat(5, 5, 1);

        // Zero-count command: finish next cycle, no start, counters held
        r0 = n_rise;
        issue_cmd(0, 3, 3, 1);
        chk("zero_finish", finish, 1);
        tick();
        chk("zero_finish_drop", finish, 0);
        chk("zero_no_start", n_rise - r0, 0);

        // Overlap bound: dones withheld
        k_done_en = 1'b0;
        issue_cmd(4, 4, 4, 1);
        repeat (20) tick();
        chk("bound_starts", starts_issued, 2);
        chk("bound_ap_start", ap_start, 0);
        chk("bound_dones", dones_seen, 0);
        k_done_en = 1'b1;
        k = 0;
        while (dones_seen != 1 && k < 20) begin tick(); k++; end
        chk("bound_first_done", dones_seen, 1);
        chk("bound_starts_at_done", starts_issued, 2);
        k = 0;
        while (starts_issued != 3 && k < 10) begin tick(); k++; end
        chk("bound_third_start", starts_issued, 3);
        wait_finish(200);

        // Back-pressure from the sink
        sink_ready = 1'b0;
        issue_cmd(2, 2, 2, 1);
        k = 0;
        while (ap_done != 1'b1 && k < 30) begin tick(); k++; end
        chk("bp_done_seen", ap_done, 1);
        d0 = int'(dones_seen);
        f0 = n_finish;
        repeat (10) tick();
        chk("bp_continue_low", ap_continue, 0);
        chk("bp_dones_frozen", dones_seen, d0);
        chk("bp_done_held", ap_done, 1);
        chk("bp_no_finish", n_finish - f0, 0);
        sink_ready = 1'b1;
        tick();
        chk("bp_release_1", dones_seen, d0 + 1);
        tick();
        chk("bp_release_2", dones_seen, d0 + 2);
        wait_finish(50);

        // Start and done handshake in the same cycle
        dly_q.push_back(2);
        n_both = 0;
        issue_cmd(3, 3, 3, 1);
        wait_finish(200);
        chk("same_cycle_seen", n_both, 1);
        chk("same_cycle_no_err", err_spurious, 0);

        // Spurious done while nothing is outstanding
        issue_cmd(1, 1, 2, 1);
        chk_lat(0, 0, 0);
        ap_done = 1'b1;
        tick();
        chk("spur_err", err_spurious, 1);
        chk("spur_dones", dones_seen, 1);
        wait_finish(100);
        chk("spur_sticky", err_spurious, 1);
        chk_lat(5, 5, 1);

        // Reset in the middle of a run
        issue_cmd(5, 0, 0, 0);
        chk("accept_clears_err", err_spurious, 0);
        chk("accept_clears_starts", starts_issued, 0);
        chk("mid_ap_start", ap_start, 1);
        reset = 1'b1;
        due_q.delete();
        dly_q.delete();
        out_m = 0;
        tick();
        chk("mid_rst_ap_start", ap_start, 0);
        chk("mid_rst_cmd_ready", cmd_ready, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_starts", starts_issued, 0);
        reset = 1'b0;
        tick();

        // Latency spread 6, 9, 7
        dly_q.push_back(6);
        dly_q.push_back(9);
        dly_q.push_back(7);
        issue_cmd(3, 3, 3, 1);
        wait_finish(200);
        chk_lat(6, 9, 1);
        chk("sb_drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
